// File: rtl/e203_tohost_resp.sv
// ICB responder for the tohost test-status window: decodes CPU stores into
// done/pass/fail/timeout flags and keeps cycle and retired-instruction statistics.
module e203_tohost_resp #(
  parameter int AW          = 16,
  parameter int DONE_WRITES = 8,
  parameter int TIMEOUT     = 10000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [AW-1:0] icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [31:0]   icb_cmd_wdata,
  input  logic [3:0]    icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [31:0]   icb_rsp_rdata,
  output logic          icb_rsp_err,
  input  logic          cmt_valid,
  output logic          test_done,
  output logic          test_pass,
  output logic          test_fail,
  output logic          test_timeout
);

  localparam logic [2:0]  SEL_TOHOST    = 3'd0;
  localparam logic [2:0]  SEL_CYCLE     = 3'd1;
  localparam logic [2:0]  SEL_END_CYCLE = 3'd2;
  localparam logic [2:0]  SEL_WR_CNT    = 3'd3;
  localparam logic [2:0]  SEL_INSTRET   = 3'd4;
  localparam logic [2:0]  SEL_STATUS    = 3'd5;
  localparam logic [31:0] DONE_CNT      = 32'(DONE_WRITES);
  localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT - 1);

  logic [31:0] tohost_q, tohost_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] end_cycle_q, end_cycle_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] instret_q, instret_d;
  logic        first_wr_q, first_wr_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [2:0]  sel;
  logic        aligned;
  logic        rd_ok;
  logic        wr_ok;
  logic        accept;
  logic        tohost_wr;
  logic        pass_w;
  logic        fail_w;
  logic [31:0] reg_val;
  logic [31:0] tohost_merged;
  logic        addr_unused;

  // Only offset bits [4:0] are decoded; the window aliases across the rest.
  assign addr_unused = ^icb_cmd_addr[AW-1:5];
  assign sel         = icb_cmd_addr[4:2];
  assign aligned     = (icb_cmd_addr[1:0] == 2'b00);
  assign rd_ok       = aligned && (sel <= SEL_STATUS);
  assign wr_ok       = aligned && (sel == SEL_TOHOST);

  assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;
  assign accept        = icb_cmd_valid & icb_cmd_ready;
  assign tohost_wr     = accept & ~icb_cmd_read & wr_ok;

  assign pass_w = done_q & (tohost_q == 32'd1);
  assign fail_w = done_q & (tohost_q != 32'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign tohost_merged[gi*8 +: 8] = icb_cmd_wmask[gi] ? icb_cmd_wdata[gi*8 +: 8]
                                                          : tohost_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    reg_val = 32'd0;
    case (sel)
      SEL_TOHOST:    reg_val = tohost_q;
      SEL_CYCLE:     reg_val = cycle_q;
      SEL_END_CYCLE: reg_val = end_cycle_q;
      SEL_WR_CNT:    reg_val = wr_cnt_q;
      SEL_INSTRET:   reg_val = instret_q;
      SEL_STATUS:    reg_val = {27'd0, first_wr_q, timeout_q, fail_w, pass_w, done_q};
      default:       reg_val = 32'd0;
    endcase
  end

  always_comb begin
    tohost_d    = tohost_q;
    cycle_d     = cycle_q + 32'd1;
    end_cycle_d = end_cycle_q;
    wr_cnt_d    = wr_cnt_q;
    instret_d   = instret_q;
    first_wr_d  = first_wr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (tohost_wr) begin
      tohost_d = tohost_merged;
      if (wr_cnt_q != 32'hFFFF_FFFF) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end
      if (!first_wr_q) begin
        first_wr_d  = 1'b1;
        end_cycle_d = cycle_q;
      end
    end

    // A retirement on the same edge as the first tohost write is excluded.
    if (cmt_valid && !first_wr_q && !tohost_wr) begin
      instret_d = instret_q + 32'd1;
    end

    done_d    = done_q | (tohost_wr && (wr_cnt_d == DONE_CNT));
    timeout_d = timeout_q | (!done_d && (cycle_q == TIMEOUT_LAST));

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = (icb_cmd_read && rd_ok) ? reg_val : 32'd0;
      rsp_err_d   = icb_cmd_read ? ~rd_ok : ~wr_ok;
    end else if (icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tohost_q    <= 32'd0;
      cycle_q     <= 32'd0;
      end_cycle_q <= 32'd0;
      wr_cnt_q    <= 32'd0;
      instret_q   <= 32'd0;
      first_wr_q  <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      tohost_q    <= tohost_d;
      cycle_q     <= cycle_d;
      end_cycle_q <= end_cycle_d;
      wr_cnt_q    <= wr_cnt_d;
      instret_q   <= instret_d;
      first_wr_q  <= first_wr_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign icb_rsp_err   = rsp_err_q;
  assign test_done     = done_q;
  assign test_pass     = pass_w;
  assign test_fail     = fail_w;
  assign test_timeout  = timeout_q;

endmodule

// File: tb/tb_e203_tohost_resp.sv
// Directed bench for e203_tohost_resp, built with a short timeout so the
// timeout flag can be observed within a few hundred cycles.
module tb_e203_tohost_resp;

  logic        clk;
  logic        rst;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [15:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        cmt_valid;
  logic        test_done;
  logic        test_pass;
  logic        test_fail;
  logic        test_timeout;

  int          vectors;
  int          miscompares;
  logic [31:0] cyc;
  logic [31:0] rd;
  logic        er;
  logic        rv;
  logic [31:0] ac;

  e203_tohost_resp #(.AW(16), .DONE_WRITES(8), .TIMEOUT(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .cmt_valid     (cmt_valid),
    .test_done     (test_done),
    .test_pass     (test_pass),
    .test_fail     (test_fail),
    .test_timeout  (test_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter since reset release: the expected CYCLE value.
  always @(posedge clk) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst           = 1'b1;
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = 16'd0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = 32'd0;
    icb_cmd_wmask = 4'd0;
    icb_rsp_ready = 1'b1;
    cmt_valid     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One transaction with rsp_ready held high; returns the response sampled
  // after the accept edge and the CYCLE value at the accept edge.
  task automatic xact(input logic rd_n, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] wm, output logic [31:0] rdata, output logic err,
                      output logic valid, output logic [31:0] acc);
    int n;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd_n;
    icb_cmd_addr  = addr;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    icb_rsp_ready = 1'b1;
    n = 0;
    #1;
    while (!icb_cmd_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) begin
      miscompares++;
      $display("FAIL cmd_accept_wait: cmd_ready stayed %0b, required 1", icb_cmd_ready);
    end
    acc = cyc;
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    rdata = icb_rsp_rdata;
    err   = icb_rsp_err;
    valid = icb_rsp_valid;
  endtask

  task automatic test_reset;
    logic [31:0] r1;
    do_reset();
    vectors++;
    if ({icb_rsp_valid, test_done, test_pass, test_fail, test_timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 00000",
               {icb_rsp_valid, test_done, test_pass, test_fail, test_timeout});
    end
    xact(1'b1, 16'h0014, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_status: got v=%0b err=%0b rdata=%h required v=1 err=0 rdata=0", rv, er, rd);
    end
    xact(1'b1, 16'h0004, 32'd0, 4'd0, rd, er, rv, ac);
    r1 = rd;
    vectors++;
    if (rd !== 32'd1) begin
      miscompares++;
      $display("FAIL cycle_first: got %h required 00000001", rd);
    end
    repeat (10) @(posedge clk);
    #1;
    xact(1'b1, 16'h0004, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd - r1 !== 32'd11 || rd !== ac) begin
      miscompares++;
      $display("FAIL cycle_delta: got %h (first %h) required %h", rd, r1, ac);
    end
  endtask

  task automatic test_instret;
    logic [31:0] wacc;
    do_reset();
    cmt_valid = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    xact(1'b0, 16'h0000, 32'h1, 4'hF, rd, er, rv, wacc);
    cmt_valid = 1'b0;
    vectors++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL tohost_wr_rsp: got v=%0b err=%0b rdata=%h required v=1 err=0 rdata=0", rv, er, rd);
    end
    xact(1'b1, 16'h0010, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'd50) begin
      miscompares++;
      $display("FAIL instret: got %0d required 50", rd);
    end
    xact(1'b1, 16'h0008, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'd50 || rd !== wacc) begin
      miscompares++;
      $display("FAIL end_cycle: got %0d required 50 (accept cycle %0d)", rd, wacc);
    end
    xact(1'b1, 16'h0014, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'h10 || test_done !== 1'b0) begin
      miscompares++;
      $display("FAIL status_first_wr: got %h done=%0b required 00000010 done=0", rd, test_done);
    end
  endtask

  task automatic test_done_pass_fail;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      xact(1'b0, 16'h0000, 32'h1, 4'hF, rd, er, rv, ac);
      if (i == 6) begin
        vectors++;
        if (test_done !== 1'b0) begin
          miscompares++;
          $display("FAIL done_early: got %0b after 7 writes required 0", test_done);
        end
      end
    end
    vectors++;
    if ({test_done, test_pass, test_fail} !== 3'b110) begin
      miscompares++;
      $display("FAIL done_pass: got done/pass/fail=%b required 110", {test_done, test_pass, test_fail});
    end
    xact(1'b1, 16'h000C, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'd8) begin
      miscompares++;
      $display("FAIL wr_cnt_8: got %0d required 8", rd);
    end
    xact(1'b0, 16'h0000, 32'h3, 4'hF, rd, er, rv, ac);
    vectors++;
    if ({test_done, test_pass, test_fail} !== 3'b101) begin
      miscompares++;
      $display("FAIL done_fail: got done/pass/fail=%b required 101", {test_done, test_pass, test_fail});
    end
    xact(1'b1, 16'h0014, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'h15) begin
      miscompares++;
      $display("FAIL status_done: got %h required 00000015", rd);
    end
  endtask

  task automatic test_wmask;
    xact(1'b0, 16'h0000, 32'hAABBCCDD, 4'b0101, rd, er, rv, ac);
    xact(1'b1, 16'h0000, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'h00BB00DD) begin
      miscompares++;
      $display("FAIL wmask_merge: got %h required 00BB00DD", rd);
    end
    xact(1'b0, 16'h0000, 32'hFFFFFFFF, 4'b0000, rd, er, rv, ac);
    vectors++;
    if ({rv, er} !== 2'b10) begin
      miscompares++;
      $display("FAIL wmask0_rsp: got v=%0b err=%0b required v=1 err=0", rv, er);
    end
    xact(1'b1, 16'h0000, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'h00BB00DD) begin
      miscompares++;
      $display("FAIL wmask0_data: got %h required 00BB00DD", rd);
    end
    xact(1'b1, 16'h000C, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'd11) begin
      miscompares++;
      $display("FAIL wr_cnt_11: got %0d required 11", rd);
    end
  endtask

  task automatic test_errors;
    do_reset();
    xact(1'b0, 16'h0004, 32'h12345678, 4'hF, rd, er, rv, ac);
    vectors++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL err_wr_cycle: got v=%0b err=%0b rdata=%h required v=1 err=1 rdata=0", rv, er, rd);
    end
    xact(1'b1, 16'h0018, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL err_rd_18: got v=%0b err=%0b rdata=%h required v=1 err=1 rdata=0", rv, er, rd);
    end
    xact(1'b1, 16'h0002, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL err_rd_unaligned: got v=%0b err=%0b rdata=%h required v=1 err=1 rdata=0", rv, er, rd);
    end
    xact(1'b0, 16'h0001, 32'h5, 4'hF, rd, er, rv, ac);
    vectors++;
    if ({rv, er} !== 2'b11) begin
      miscompares++;
      $display("FAIL err_wr_unaligned: got v=%0b err=%0b required v=1 err=1", rv, er);
    end
    xact(1'b1, 16'h0100, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if ({er, rd} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL err_tohost_unchanged: got err=%0b rdata=%h required err=0 rdata=0", er, rd);
    end
    xact(1'b1, 16'h0014, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if ({er, rd} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL err_status_unchanged: got err=%0b rdata=%h required err=0 rdata=0", er, rd);
    end
  endtask

  task automatic test_stall;
    do_reset();
    xact(1'b0, 16'h0000, 32'h5A5A1234, 4'hF, rd, er, rv, ac);
    @(posedge clk);
    #1;
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 16'h0000;
    @(posedge clk);
    #1;
    icb_cmd_addr = 16'h000C;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata} !== {1'b0, 1'b1, 1'b0, 32'h5A5A1234}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got ready=%0b v=%0b err=%0b rdata=%h required ready=0 v=1 err=0 rdata=5A5A1234",
                 i, icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
      end
      @(posedge clk);
      #1;
    end
    icb_rsp_ready = 1'b1;
    #1;
    vectors++;
    if (icb_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %0b required 1", icb_cmd_ready);
    end
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    vectors++;
    if ({icb_rsp_valid, icb_rsp_rdata} !== {1'b1, 32'd1}) begin
      miscompares++;
      $display("FAIL stall_next_cmd: got v=%0b rdata=%h required v=1 rdata=00000001", icb_rsp_valid, icb_rsp_rdata);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    icb_rsp_ready = 1'b1;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = 16'h0000;
    icb_cmd_wmask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      icb_cmd_wdata = 32'(i + 1);
      #1;
      vectors++;
      if (icb_cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: got %0b required 1", i, icb_cmd_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({icb_rsp_valid, icb_rsp_err} !== 2'b10) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d]: got v=%0b err=%0b required v=1 err=0", i, icb_rsp_valid, icb_rsp_err);
      end
    end
    icb_cmd_valid = 1'b0;
    xact(1'b1, 16'h000C, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'd3) begin
      miscompares++;
      $display("FAIL b2b_wr_cnt: got %0d required 3", rd);
    end
    xact(1'b1, 16'h0000, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'd3) begin
      miscompares++;
      $display("FAIL b2b_tohost: got %h required 00000003", rd);
    end
  endtask

  task automatic test_timeout_and_reset;
    do_reset();
    repeat (99) @(posedge clk);
    #1;
    vectors++;
    if (test_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got %0b at cycle 99 required 0", test_timeout);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (test_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_at_100: got %0b required 1", test_timeout);
    end
    xact(1'b1, 16'h0014, 32'd0, 4'd0, rd, er, rv, ac);
    vectors++;
    if (rd !== 32'h8) begin
      miscompares++;
      $display("FAIL status_timeout: got %h required 00000008", rd);
    end
    @(posedge clk);
    #1;
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 16'h0014;
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    vectors++;
    if (icb_rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_rsp: got v=%0b required 1", icb_rsp_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({icb_rsp_valid, test_done, test_pass, test_fail, test_timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_rsp_reset: got %b required 00000",
               {icb_rsp_valid, test_done, test_pass, test_fail, test_timeout});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_instret();
    test_done_pass_fail();
    test_wmask();
    test_errors();
    test_stall();
    test_back_to_back();
    test_timeout_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/e203_tohost_resp.md
Name: e203_tohost_resp

Overview:
- Synthesizable ICB responder that terminates CPU stores to the test-status ("tohost") window.
- Turns those stores into pass/fail/done indications plus cycle and instruction statistics.
- Sits on a spare private-peripheral ICB slave port of e203_subsys_main.
- Lets FPGA and emulation builds self-report test results without a simulation bench probing core internals.

Parameters:
- AW, 16, ICB address bits decoded (only cmd_addr[4:2] is significant; upper bits ignored).
- DONE_WRITES, 8, number of TOHOST writes after which the test is declared done.
- TIMEOUT, 10000000, cycles after reset with no done before timeout asserts.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted
- icb_cmd_addr  in  AW  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted
- icb_rsp_rdata  out  32  read data
- icb_rsp_err  out  1  response error
- cmt_valid  in  1  one instruction retired this cycle
- test_done  out  1  write count reached DONE_WRITES
- test_pass  out  1  done and last TOHOST value == 1
- test_fail  out  1  done and last TOHOST value != 1
- test_timeout  out  1  TIMEOUT reached before done

Behaviour:
- Reset (rst high at a clk edge) clears all state. All outputs 0. Reset is honoured mid-transaction: a pending response is dropped.
- Register map (offset = cmd_addr[4:0]):
  - 0x00 TOHOST: RW, 32b, last written value.
  - 0x04 CYCLE: RO, free-running 32b counter; wraps at 2^32.
  - 0x08 END_CYCLE: RO, CYCLE value sampled on the first TOHOST write.
  - 0x0C WR_CNT: RO, TOHOST write count; saturates at 0xFFFFFFFF.
  - 0x10 INSTRET: RO, cmt_valid count while no TOHOST write has occurred yet.
  - 0x14 STATUS: RO, bit0 done, bit1 pass, bit2 fail, bit3 timeout, bit4 first_wr; other bits 0.
  - Offsets 0x18-0x1C and any unaligned address (addr[1:0]!=0): error.
- Handshake:
  - Single outstanding transaction.
  - icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready.
  - Command accepted when valid & ready.
  - icb_rsp_valid rises the cycle after acceptance and holds, with rdata/err stable, until icb_rsp_ready.
  - Back-to-back throughput: one transaction per cycle when rsp_ready is held high.
- Reads: rdata = register value at the accept edge. Error reads return rdata 0, err 1.
- Writes:
  - TOHOST write merges bytes per wmask.
  - wmask==0 is a legal no-op write but still counts in WR_CNT.
  - Writes to RO or unmapped offsets: no state change, err 1.
  - Write responses carry rdata 0.
- First TOHOST write: END_CYCLE captured, first_wr set. INSTRET stops counting on the same edge; a cmt_valid on that edge is not counted.
- done: set on the edge where WR_CNT becomes DONE_WRITES, sticky until rst.
- pass/fail:
  - Evaluated combinationally from done and the current TOHOST value.
  - Writes after done still update TOHOST, so pass/fail may change.
  - pass and fail are never both 1.
- timeout:
  - Sticky. Set when CYCLE == TIMEOUT-1 and done==0.
  - Never set once done. If done is set on the same edge, done wins and timeout stays 0.
- INSTRET and CYCLE keep counting across ICB stalls. Wrap of CYCLE has no effect on flags.

Test Plan:
- After reset, read STATUS -> rdata 0x0, err 0. Read CYCLE at two points 10 cycles apart -> values differ by 10 (±handshake offset).
- With cmt_valid high for 50 cycles, then write TOHOST=0x1 -> INSTRET 50, END_CYCLE equals CYCLE at the accept edge, first_wr=1, done=0.
- Write TOHOST=0x1 eight times with full wmask -> WR_CNT 8; test_done=1, test_pass=1, test_fail=0. A ninth write of 0x3 -> test_pass=0, test_fail=1.
- Write to CYCLE (0x04), read 0x18, read 0x02 -> three responses with err=1. Register contents unchanged.
- Hold icb_rsp_ready=0 for 5 cycles after a read -> cmd_ready=0 and rsp data stable throughout. Release -> next command accepted the same cycle.
- Build with TIMEOUT=100 and issue no writes -> test_timeout rises exactly at cycle 100 after reset. Assert rst mid-response -> all flags and rsp_valid 0 the next cycle.
